// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester ports, lock and data-memory bus of the arbiter
interface dmem_arbiter_if #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 10
);
  logic                     req_a, req_b;
  logic                     we_a, we_b;
  logic [RAM_ADDR_BITS-1:0] addr_a, addr_b;
  logic [RAM_WIDTH-1:0]     wdata_a, wdata_b;
  logic                     lock_b;
  logic                     gnt_a, gnt_b;
  logic                     rvalid_a, rvalid_b;
  logic [RAM_WIDTH-1:0]     rdata_a, rdata_b;
  logic                     mem_write;
  logic [RAM_ADDR_BITS-1:0] mem_addr;
  logic [RAM_WIDTH-1:0]     mem_wdata;
  logic [RAM_WIDTH-1:0]     mem_rdata;
  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, lock_b, mem_rdata,
    output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, mem_write, mem_addr, mem_wdata
  );
  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, lock_b, mem_rdata,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter of pipeline (A) and debug (B) ports onto one data memory
module dmem_arbiter #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 10
) (
  input logic              clk,
  input logic              reset,
  dmem_arbiter_if.slave    bus
);
  logic                     gnt_a_q, gnt_b_q, gnt_a_d, gnt_b_d;
  logic                     last_b_q, last_b_d;
  logic                     mem_write_q, mem_write_d;
  logic [RAM_ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [RAM_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic                     rd1_v_q, rd1_b_q, rd2_v_q, rd2_b_q, rd1_v_d;
  logic                     rvalid_a_q, rvalid_b_q;
  logic [RAM_WIDTH-1:0]     rdata_a_q, rdata_b_q;
  logic                     elig_a, elig_b, gnt_any, we_sel;
  // arbitration: a port just granted sits out one edge; ties go to the port not served last
  always_comb begin
    elig_a      = bus.req_a & ~gnt_a_q & ~bus.lock_b;
    elig_b      = bus.req_b & ~gnt_b_q;
    gnt_a_d     = elig_a & (~elig_b | last_b_q);
    gnt_b_d     = elig_b & ~gnt_a_d;
    gnt_any     = gnt_a_d | gnt_b_d;
    we_sel      = gnt_a_d ? bus.we_a : bus.we_b;
    mem_write_d = gnt_any & we_sel;
    mem_addr_d  = gnt_a_d ? bus.addr_a : gnt_b_d ? bus.addr_b : mem_addr_q;
    mem_wdata_d = gnt_a_d ? bus.wdata_a : gnt_b_d ? bus.wdata_b : mem_wdata_q;
    last_b_d    = gnt_a_d ? 1'b0 : gnt_b_d ? 1'b1 : last_b_q;
    rd1_v_d     = gnt_any & ~we_sel;
  end
  // registered outputs plus a two-stage (valid, port) tracker that steers read data back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      last_b_q    <= 1'b1;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd1_v_q     <= 1'b0;
      rd1_b_q     <= 1'b0;
      rd2_v_q     <= 1'b0;
      rd2_b_q     <= 1'b0;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
    end else begin
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      last_b_q    <= last_b_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd1_v_q     <= rd1_v_d;
      rd1_b_q     <= gnt_b_d;
      rd2_v_q     <= rd1_v_q;
      rd2_b_q     <= rd1_b_q;
      rvalid_a_q  <= rd2_v_q & ~rd2_b_q;
      rvalid_b_q  <= rd2_v_q & rd2_b_q;
      if (rd2_v_q & ~rd2_b_q) rdata_a_q <= bus.mem_rdata;
      if (rd2_v_q & rd2_b_q) rdata_b_q <= bus.mem_rdata;
    end
  end
  assign bus.gnt_a     = gnt_a_q;
  assign bus.gnt_b     = gnt_b_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rvalid_a  = rvalid_a_q;
  assign bus.rvalid_b  = rvalid_b_q;
  assign bus.rdata_a   = rdata_a_q;
  assign bus.rdata_b   = rdata_b_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural data memory
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic        port;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
  } gnt_t;
  gnt_t        gq[$];
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] mem [0:1023];
  dmem_arbiter_if #(.RAM_WIDTH(32), .RAM_ADDR_BITS(10)) bus ();
  dmem_arbiter #(.RAM_WIDTH(32), .RAM_ADDR_BITS(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
    else bus.mem_rdata <= mem[bus.mem_addr];
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " gnt_a"}, 32'(bus.gnt_a), 0);
    chk({tag, " gnt_b"}, 32'(bus.gnt_b), 0);
    chk({tag, " rvalid_a"}, 32'(bus.rvalid_a), 0);
    chk({tag, " rvalid_b"}, 32'(bus.rvalid_b), 0);
    chk({tag, " mem_write"}, 32'(bus.mem_write), 0);
    chk({tag, " mem_addr"}, 32'(bus.mem_addr), 0);
    chk({tag, " mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, " rdata_a"}, bus.rdata_a, 0);
    chk({tag, " rdata_b"}, bus.rdata_b, 0);
  endtask
  task automatic exp_gnt(input logic p, input logic w, input logic [9:0] a, input logic [31:0] d);
    gnt_t e;
    e.port = p;
    e.we = w;
    e.addr = a;
    e.wdata = d;
    gq.push_back(e);
  endtask
  // monitor: every grant / rvalid the DUT shows is matched against the scoreboard queues
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.gnt_a || bus.gnt_b) begin
        if (gq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_gnt: got gnt_a=%b gnt_b=%b expected none", bus.gnt_a, bus.gnt_b);
        end else begin
          gnt_t e;
          e = gq.pop_front();
          chk("gnt_one_hot", 32'(bus.gnt_a & bus.gnt_b), 0);
          chk("gnt_port", 32'(bus.gnt_b), 32'(e.port));
          chk("mem_write", 32'(bus.mem_write), 32'(e.we));
          chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
          if (e.we) chk("mem_wdata", bus.mem_wdata, e.wdata);
        end
      end else if (bus.mem_write) begin
        checks++;
        errors++;
        $display("FAIL write_without_gnt: got mem_write=1 expected 0");
      end
      if (bus.rvalid_a) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid_a: got rdata_a=%h expected no rvalid", bus.rdata_a);
        end else chk("rdata_a", bus.rdata_a, qa.pop_front());
      end
      if (bus.rvalid_b) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid_b: got rdata_b=%h expected no rvalid", bus.rdata_b);
        end else chk("rdata_b", bus.rdata_b, qb.pop_front());
      end
    end
  end
  initial begin
    bus.req_a = 0; bus.req_b = 0; bus.we_a = 0; bus.we_b = 0;
    bus.addr_a = 0; bus.addr_b = 0; bus.wdata_a = 0; bus.wdata_b = 0; bus.lock_b = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 0;
    mem[1] = 32'h11;
    mem[2] = 32'h22;
    step(2);
    chk_zero("reset");
    reset = 1'b0;
    // write then read back on port A
    bus.req_a = 1; bus.we_a = 1; bus.addr_a = 5; bus.wdata_a = 32'hDEADBEEF;
    exp_gnt(0, 1, 5, 32'hDEADBEEF);
    exp_gnt(0, 0, 5, 0);
    qa.push_back(32'hDEADBEEF);
    step(1);
    bus.we_a = 0;
    step(2);
    bus.req_a = 0;
    step(4);
    // both ports reading, LAST=A so B wins first
    bus.req_a = 1; bus.we_a = 0; bus.addr_a = 1;
    bus.req_b = 1; bus.we_b = 0; bus.addr_b = 2;
    exp_gnt(1, 0, 2, 0); exp_gnt(0, 0, 1, 0); exp_gnt(1, 0, 2, 0); exp_gnt(0, 0, 1, 0);
    qb.push_back(32'h22); qb.push_back(32'h22);
    qa.push_back(32'h11); qa.push_back(32'h11);
    step(4);
    bus.req_a = 0; bus.req_b = 0;
    step(4);
    // lock_b blocks A; B every other edge; A wins the tie once lock drops
    bus.lock_b = 1; bus.req_a = 1; bus.req_b = 1;
    exp_gnt(1, 0, 2, 0); exp_gnt(1, 0, 2, 0); exp_gnt(0, 0, 1, 0);
    qb.push_back(32'h22); qb.push_back(32'h22);
    qa.push_back(32'h11);
    step(4);
    bus.lock_b = 0;
    step(1);
    bus.req_a = 0; bus.req_b = 0;
    step(4);
    // B writes addr 7, A reads it on the next edge
    bus.req_b = 1; bus.we_b = 1; bus.addr_b = 7; bus.wdata_b = 32'h12345678;
    bus.req_a = 1; bus.we_a = 0; bus.addr_a = 7;
    exp_gnt(1, 1, 7, 32'h12345678); exp_gnt(0, 0, 7, 0);
    qa.push_back(32'h12345678);
    step(2);
    bus.req_a = 0; bus.req_b = 0; bus.we_b = 0;
    step(4);
    // idle: nothing granted, address register holds
    step(10);
    chk("idle mem_addr", 32'(bus.mem_addr), 7);
    chk("idle mem_write", 32'(bus.mem_write), 0);
    // reset with an A read in flight
    bus.req_a = 1; bus.we_a = 0; bus.addr_a = 1;
    exp_gnt(0, 0, 1, 0);
    step(1);
    bus.req_a = 0;
    step(1);
    reset = 1'b1;
    #1;
    chk_zero("midreset");
    step(2);
    bus.req_a = 1; bus.addr_a = 1; bus.req_b = 1; bus.we_b = 0; bus.addr_b = 2;
    reset = 1'b0;
    exp_gnt(0, 0, 1, 0);
    qa.push_back(32'h11);
    step(1);
    bus.req_a = 0; bus.req_b = 0;
    step(6);
    chk("gnt_queue_empty", 32'(gq.size()), 0);
    chk("rd_a_queue_empty", 32'(qa.size()), 0);
    chk("rd_b_queue_empty", 32'(qb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
